// File: rtl/kf8259_interrupt_sequencer.sv
// kf8259_interrupt_sequencer
// Rotating-priority resolver, in-service register owner and two-pulse 8086
// INTA sequencer for the 8259 core. Every output is registered, so the
// effects of an INTA falling edge appear right after the clock edge that
// samples it.
// Optional feature macro: KF8259_AUTO_ROTATE_EN. It adds the auto_rotate_config
// input, and an automatic EOI then also rotates the priority order.
module kf8259_interrupt_sequencer #(
    parameter logic [2:0] DEFAULT_LOWEST_PRIORITY = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi_config,
`ifdef KF8259_AUTO_ROTATE_EN
    input  logic       auto_rotate_config,
`endif
    input  logic       nonspecific_eoi,
    input  logic       specific_eoi,
    input  logic       rotate_on_eoi,
    input  logic       set_priority,
    input  logic [2:0] eoi_level,
    input  logic       interrupt_acknowledge_n,
    output logic       interrupt_to_cpu,
    output logic       freeze,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [7:0] vector_out,
    output logic       vector_out_enable
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK1 = 2'd1,
        S_GAP  = 2'd2,
        S_ACK2 = 2'd3
    } state_t;

    // Rotate right so that bit 0 of the result is the level n of the input.
    function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] w;
        w = {v, v} >> n;
        return w[7:0];
    endfunction

    // {found, index} of the least significant set bit.
    function automatic logic [3:0] first_set(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    state_t     r_state;
    state_t     w_next_state;
    logic       r_inta_prev;
    logic [7:0] r_isr;
    logic [2:0] r_lowest;
    logic [2:0] r_ack_level;
    logic       r_spurious;
    logic       r_int;
    logic       r_freeze;
    logic       r_vec_en;
    logic [7:0] r_clear;
    logic [7:0] r_vector;

    logic [2:0] w_shift;
    logic [7:0] w_cand_rot;
    logic [7:0] w_isr_rot;
    logic [7:0] w_higher_mask;
    logic [7:0] w_win_rot;
    logic [3:0] w_isr_first;
    logic [3:0] w_win_first;
    logic       w_winner_valid;
    logic [2:0] w_winner_level;
    logic [2:0] w_isr_top_level;
    logic       w_inta_fall;
    logic       w_ack_take;
    logic       w_aeoi_clear;
    logic       w_aeoi_rotate;
    logic       w_eoi_valid;
    logic [2:0] w_eoi_level;
    logic [7:0] w_set_mask;
    logic [7:0] w_eoi_mask;
    logic [7:0] w_aeoi_mask;
    logic [7:0] w_next_isr;
    logic [2:0] w_next_lowest;
    logic [2:0] w_next_ack_level;
    logic       w_next_spurious;
    logic       w_next_int;
    logic       w_next_freeze;
    logic       w_next_vec_en;
    logic [7:0] w_next_clear;
    logic [7:0] w_next_vector;

    // Priority resolution happens in a rotated frame where bit 0 is the
    // highest-priority level (lowest_priority + 1), so "higher" is "lower index".
    assign w_shift         = r_lowest + 3'd1;
    assign w_cand_rot      = rotate_right(interrupt_request_register & ~interrupt_mask, w_shift);
    assign w_isr_rot       = rotate_right(r_isr, w_shift);
    assign w_isr_first     = first_set(w_isr_rot);
    assign w_higher_mask   = w_isr_first[3] ? ((8'h01 << w_isr_first[2:0]) - 8'h01) : 8'hFF;
    assign w_win_rot       = w_cand_rot & w_higher_mask;
    assign w_win_first     = first_set(w_win_rot);
    assign w_winner_valid  = w_win_first[3];
    assign w_winner_level  = w_win_first[2:0] + w_shift;
    assign w_isr_top_level = w_isr_first[2:0] + w_shift;

    assign w_inta_fall  = r_inta_prev & ~interrupt_acknowledge_n;
    assign w_ack_take   = (r_state == S_IDLE) && w_inta_fall;
    assign w_aeoi_clear = (r_state == S_ACK2) && interrupt_acknowledge_n &&
                          auto_eoi_config && !r_spurious;

`ifdef KF8259_AUTO_ROTATE_EN
    assign w_aeoi_rotate = w_aeoi_clear && auto_rotate_config;
`else
    assign w_aeoi_rotate = 1'b0;
`endif

    // Select which ISR level an EOI command clears; specific beats nonspecific.
    always_comb begin
        w_eoi_valid = 1'b0;
        w_eoi_level = 3'd0;
        if (specific_eoi) begin
            w_eoi_valid = 1'b1;
            w_eoi_level = eoi_level;
        end else if (nonspecific_eoi && w_isr_first[3]) begin
            w_eoi_valid = 1'b1;
            w_eoi_level = w_isr_top_level;
        end
    end

    // State register and registered INTA sample used for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_inta_prev <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_inta_prev <= interrupt_acknowledge_n;
        end
    end

    // Next-state logic for the two-pulse acknowledge sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_inta_fall)             w_next_state = S_ACK1;
            S_ACK1:  if (interrupt_acknowledge_n) w_next_state = S_GAP;
            S_GAP:   if (w_inta_fall)             w_next_state = S_ACK2;
            S_ACK2:  if (interrupt_acknowledge_n) w_next_state = S_IDLE;
            default:                              w_next_state = S_IDLE;
        endcase
    end

    // Output and datapath next values: ISR set/clear, priority rotation, pins.
    always_comb begin
        w_next_ack_level = r_ack_level;
        w_next_spurious  = r_spurious;
        w_set_mask       = 8'h00;
        w_next_clear     = 8'h00;
        if (w_ack_take) begin
            if (w_winner_valid) begin
                w_next_ack_level = w_winner_level;
                w_next_spurious  = 1'b0;
                w_set_mask       = 8'h01 << w_winner_level;
                w_next_clear     = 8'h01 << w_winner_level;
            end else begin
                w_next_ack_level = 3'd7;
                w_next_spurious  = 1'b1;
            end
        end

        // A set in the same cycle as a clear of the same bit must win.
        w_aeoi_mask = w_aeoi_clear ? (8'h01 << r_ack_level) : 8'h00;
        w_eoi_mask  = w_eoi_valid ? (8'h01 << w_eoi_level) : 8'h00;
        w_next_isr  = (r_isr & ~w_eoi_mask & ~w_aeoi_mask) | w_set_mask;

        w_next_lowest = r_lowest;
        if (set_priority) begin
            w_next_lowest = eoi_level;
        end else if (rotate_on_eoi && w_eoi_valid) begin
            w_next_lowest = w_eoi_level;
        end else if (w_aeoi_rotate) begin
            w_next_lowest = r_ack_level;
        end

        w_next_int    = (r_state == S_IDLE) && !w_inta_fall && w_winner_valid;
        w_next_freeze = (w_next_state != S_IDLE);
        w_next_vec_en = (w_next_state == S_ACK2);
        w_next_vector = w_next_vec_en ? {vector_base, r_ack_level} : 8'h00;
    end

    // Registered ISR, priority pointer, acknowledge context and output pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_isr       <= 8'h00;
            r_lowest    <= DEFAULT_LOWEST_PRIORITY;
            r_ack_level <= 3'd0;
            r_spurious  <= 1'b0;
            r_int       <= 1'b0;
            r_freeze    <= 1'b0;
            r_vec_en    <= 1'b0;
            r_clear     <= 8'h00;
            r_vector    <= 8'h00;
        end else begin
            r_isr       <= w_next_isr;
            r_lowest    <= w_next_lowest;
            r_ack_level <= w_next_ack_level;
            r_spurious  <= w_next_spurious;
            r_int       <= w_next_int;
            r_freeze    <= w_next_freeze;
            r_vec_en    <= w_next_vec_en;
            r_clear     <= w_next_clear;
            r_vector    <= w_next_vector;
        end
    end

    assign interrupt_to_cpu        = r_int;
    assign freeze                  = r_freeze;
    assign clear_interrupt_request = r_clear;
    assign in_service_register     = r_isr;
    assign vector_out              = r_vector;
    assign vector_out_enable       = r_vec_en;

endmodule

// File: tb/tb_kf8259_interrupt_sequencer.sv
// Testbench for kf8259_interrupt_sequencer: directed scenarios plus a
// randomized run, checked against a transaction-level priority model.
module tb_kf8259_interrupt_sequencer;

    logic       clock;
    logic       rst_n;
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] base;
    logic       aeoi;
`ifdef KF8259_AUTO_ROTATE_EN
    logic       auto_rot;
`endif
    logic       ns_eoi;
    logic       sp_eoi;
    logic       rot_eoi;
    logic       set_pri;
    logic [2:0] eoi_lvl;
    logic       inta_n;
    logic       int_o;
    logic       frz_o;
    logic [7:0] clr_o;
    logic [7:0] isr_o;
    logic [7:0] vec_o;
    logic       ven_o;

    int n_cmp;
    int n_bad;

    // Reference state: in-service set and lowest-priority level.
    logic [7:0] m_isr;
    int         m_low;

    kf8259_interrupt_sequencer dut (
        .clock                      (clock),
        .reset                      (rst_n),
        .interrupt_request_register (irr),
        .interrupt_mask             (imr),
        .vector_base                (base),
        .auto_eoi_config            (aeoi),
`ifdef KF8259_AUTO_ROTATE_EN
        .auto_rotate_config         (auto_rot),
`endif
        .nonspecific_eoi            (ns_eoi),
        .specific_eoi               (sp_eoi),
        .rotate_on_eoi              (rot_eoi),
        .set_priority               (set_pri),
        .eoi_level                  (eoi_lvl),
        .interrupt_acknowledge_n    (inta_n),
        .interrupt_to_cpu           (int_o),
        .freeze                     (frz_o),
        .clear_interrupt_request    (clr_o),
        .in_service_register        (isr_o),
        .vector_out                 (vec_o),
        .vector_out_enable          (ven_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Highest-priority set level of v, walking the order low+1, low+2, ...
    function automatic int model_top(input logic [7:0] v, input int low);
        int r;
        r = -1;
        for (int k = 7; k >= 0; k--) begin
            if (v[(low + 1 + k) % 8]) r = (low + 1 + k) % 8;
        end
        return r;
    endfunction

    // Winner: first unmasked request, in priority order, ahead of any in-service level.
    function automatic int model_winner(input logic [7:0] rq, input logic [7:0] mk,
                                        input logic [7:0] is, input int low);
        int r;
        bit stop;
        r = -1;
        stop = 0;
        for (int k = 0; k < 8; k++) begin
            int l;
            l = (low + 1 + k) % 8;
            if (!stop && is[l]) stop = 1;
            if (!stop && r < 0 && rq[l] && !mk[l]) r = l;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ns_eoi = 0; sp_eoi = 0; rot_eoi = 0; set_pri = 0; eoi_lvl = 0;
        inta_n = 1; aeoi = 0;
`ifdef KF8259_AUTO_ROTATE_EN
        auto_rot = 0;
`endif
        tick();
        rst_n = 1'b1;
        m_isr = 8'h00;
        m_low = 7;
        tick();
    endtask

    // Full two-pulse acknowledge, checked cycle by cycle against the model.
    task automatic do_inta_cycle(input string tag);
        int         w;
        logic [7:0] exp_clr;
        logic [2:0] ack;
        bit         spur;
        w = model_winner(irr, imr, m_isr, m_low);
        inta_n = 0;
        tick();
        if (w >= 0) begin
            ack = 3'(w); exp_clr = 8'h01 << w; spur = 0; m_isr = m_isr | exp_clr;
        end else begin
            ack = 3'd7; exp_clr = 8'h00; spur = 1;
        end
        n_cmp++; if (clr_o !== exp_clr) begin n_bad++; $display("FAIL %s edge_clear got %h want %h", tag, clr_o, exp_clr); end
        n_cmp++; if (isr_o !== m_isr) begin n_bad++; $display("FAIL %s edge_isr got %h want %h", tag, isr_o, m_isr); end
        n_cmp++; if (frz_o !== 1'b1) begin n_bad++; $display("FAIL %s edge_freeze got %b want 1", tag, frz_o); end
        n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL %s edge_int got %b want 0", tag, int_o); end
        irr = irr & ~exp_clr;
        tick();
        n_cmp++; if (clr_o !== 8'h00) begin n_bad++; $display("FAIL %s clear_pulse_len got %h want 00", tag, clr_o); end
        inta_n = 1;
        tick();
        n_cmp++; if (frz_o !== 1'b1 || ven_o !== 1'b0) begin n_bad++; $display("FAIL %s gap frz/ven got %b%b want 10", tag, frz_o, ven_o); end
        inta_n = 0;
        tick();
        n_cmp++; if (ven_o !== 1'b1 || vec_o !== {base, ack}) begin n_bad++; $display("FAIL %s vector got %b/%h want 1/%h", tag, ven_o, vec_o, {base, ack}); end
        tick();
        n_cmp++; if (ven_o !== 1'b1 || frz_o !== 1'b1) begin n_bad++; $display("FAIL %s ack2_hold ven/frz got %b%b want 11", tag, ven_o, frz_o); end
        inta_n = 1;
        tick();
        if (aeoi && !spur) begin
            m_isr = m_isr & ~(8'h01 << ack);
`ifdef KF8259_AUTO_ROTATE_EN
            if (auto_rot) m_low = int'(ack);
`endif
        end
        n_cmp++; if (ven_o !== 1'b0 || frz_o !== 1'b0) begin n_bad++; $display("FAIL %s release ven/frz got %b%b want 00", tag, ven_o, frz_o); end
        n_cmp++; if (isr_o !== m_isr) begin n_bad++; $display("FAIL %s release_isr got %h want %h", tag, isr_o, m_isr); end
        tick();
        w = model_winner(irr, imr, m_isr, m_low);
        n_cmp++; if (int_o !== (w >= 0)) begin n_bad++; $display("FAIL %s post_int got %b want %b", tag, int_o, (w >= 0)); end
    endtask

    // One-cycle EOI / set-priority command, then ISR and INT checks.
    task automatic do_eoi(input string tag, input bit ns, input bit sp, input logic [2:0] lvl,
                          input bit rot, input bit setp);
        int cl;
        int w;
        ns_eoi = ns; sp_eoi = sp; eoi_lvl = lvl; rot_eoi = rot; set_pri = setp;
        tick();
        cl = -1;
        if (sp) cl = int'(lvl);
        else if (ns) cl = model_top(m_isr, m_low);
        if (cl >= 0) m_isr = m_isr & ~(8'h01 << cl);
        if (setp) m_low = int'(lvl);
        else if (rot && cl >= 0) m_low = cl;
        ns_eoi = 0; sp_eoi = 0; rot_eoi = 0; set_pri = 0;
        n_cmp++; if (isr_o !== m_isr) begin n_bad++; $display("FAIL %s eoi_isr got %h want %h", tag, isr_o, m_isr); end
        tick();
        w = model_winner(irr, imr, m_isr, m_low);
        n_cmp++; if (int_o !== (w >= 0)) begin n_bad++; $display("FAIL %s eoi_int got %b want %b", tag, int_o, (w >= 0)); end
    endtask

    task automatic test_reset();
        rst_n = 0; irr = 8'h00; imr = 8'h00; base = 5'h00; aeoi = 0;
        ns_eoi = 0; sp_eoi = 0; rot_eoi = 0; set_pri = 0; eoi_lvl = 0; inta_n = 1;
`ifdef KF8259_AUTO_ROTATE_EN
        auto_rot = 0;
`endif
        #3;
        n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL reset_int got %b want 0", int_o); end
        n_cmp++; if (frz_o !== 1'b0) begin n_bad++; $display("FAIL reset_freeze got %b want 0", frz_o); end
        n_cmp++; if (clr_o !== 8'h00) begin n_bad++; $display("FAIL reset_clear got %h want 00", clr_o); end
        n_cmp++; if (isr_o !== 8'h00) begin n_bad++; $display("FAIL reset_isr got %h want 00", isr_o); end
        n_cmp++; if (vec_o !== 8'h00 || ven_o !== 1'b0) begin n_bad++; $display("FAIL reset_vector got %h/%b want 00/0", vec_o, ven_o); end
        tick();
        rst_n = 1;
        m_isr = 8'h00;
        m_low = 7;
        tick();
        irr = 8'h08;
        #1;
        n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL int_before_latency got %b want 0", int_o); end
        tick();
        n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL int_latency got %b want 1", int_o); end
    endtask

    task automatic test_basic_ack();
        do_reset();
        base = 5'h01; imr = 8'h00; irr = 8'h0C;
        tick();
        n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL basic_int got %b want 1", int_o); end
        do_inta_cycle("basic");
        n_cmp++; if (isr_o !== 8'h04) begin n_bad++; $display("FAIL basic_isr got %h want 04", isr_o); end
        n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL basic_lower_blocked got %b want 0", int_o); end
        do_eoi("basic_ns", 1, 0, 3'd0, 0, 0);
        n_cmp++; if (isr_o !== 8'h00 || int_o !== 1'b1) begin n_bad++; $display("FAIL basic_after_eoi got %h/%b want 00/1", isr_o, int_o); end
    endtask

    task automatic test_spurious();
        irr = 8'h00;
        tick();
        do_inta_cycle("spurious");
        n_cmp++; if (isr_o !== 8'h00) begin n_bad++; $display("FAIL spurious_isr got %h want 00", isr_o); end
    endtask

    task automatic test_rotate();
        do_reset();
        irr = 8'h80; tick();
        do_inta_cycle("rot_ir7");
        irr = 8'h01; tick();
        do_inta_cycle("rot_ir0");
        n_cmp++; if (isr_o !== 8'h81) begin n_bad++; $display("FAIL rotate_isr81 got %h want 81", isr_o); end
        do_eoi("rot_ns", 1, 0, 3'd0, 1, 0);
        n_cmp++; if (isr_o !== 8'h80) begin n_bad++; $display("FAIL rotate_isr80 got %h want 80", isr_o); end
        irr = 8'h03; tick();
        n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL rotate_int got %b want 1", int_o); end
        do_inta_cycle("rot_ir1");
        n_cmp++; if (isr_o !== 8'h82) begin n_bad++; $display("FAIL rotate_winner_ir1 got %h want 82", isr_o); end
    endtask

    task automatic test_auto_eoi();
        do_reset();
        aeoi = 1;
`ifdef KF8259_AUTO_ROTATE_EN
        auto_rot = 1;
`endif
        irr = 8'h20; tick();
        do_inta_cycle("aeoi");
        n_cmp++; if (isr_o !== 8'h00) begin n_bad++; $display("FAIL aeoi_cleared got %h want 00", isr_o); end
        aeoi = 0;
        irr = 8'h41; tick();
        do_inta_cycle("aeoi_after");
`ifdef KF8259_AUTO_ROTATE_EN
        n_cmp++; if (isr_o !== 8'h40) begin n_bad++; $display("FAIL aeoi_rotated got %h want 40", isr_o); end
`else
        n_cmp++; if (isr_o !== 8'h01) begin n_bad++; $display("FAIL aeoi_not_rotated got %h want 01", isr_o); end
`endif
    endtask

    task automatic test_collisions();
        do_reset();
        irr = 8'h04; tick();
        inta_n = 0; sp_eoi = 1; eoi_lvl = 3'd2;
        tick();
        sp_eoi = 0;
        n_cmp++; if (isr_o !== 8'h04) begin n_bad++; $display("FAIL set_beats_clear got %h want 04", isr_o); end
        n_cmp++; if (clr_o !== 8'h04) begin n_bad++; $display("FAIL collision_clear got %h want 04", clr_o); end
        m_isr = 8'h04; irr = 8'h00;
        inta_n = 1; tick();
        inta_n = 0; tick();
        inta_n = 1; tick();
        tick();
        do_eoi("sp_beats_ns", 1, 1, 3'd5, 0, 0);
        n_cmp++; if (isr_o !== 8'h04) begin n_bad++; $display("FAIL specific_wins got %h want 04", isr_o); end
        do_eoi("setpri_over_rot", 0, 1, 3'd2, 1, 1);
        irr = 8'h09; tick();
        do_inta_cycle("setpri_order");
    endtask

    task automatic test_reset_midsequence();
        do_reset();
        irr = 8'h10; tick();
        inta_n = 0; tick();
        inta_n = 1; tick();
        n_cmp++; if (frz_o !== 1'b1 || isr_o !== 8'h10) begin n_bad++; $display("FAIL gap_state got %b/%h want 1/10", frz_o, isr_o); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (frz_o !== 1'b0) begin n_bad++; $display("FAIL async_freeze got %b want 0", frz_o); end
        n_cmp++; if (isr_o !== 8'h00) begin n_bad++; $display("FAIL async_isr got %h want 00", isr_o); end
        tick();
        rst_n = 1;
        m_isr = 8'h00; m_low = 7;
        tick();
        n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL idle_after_reset_int got %b want 1", int_o); end
        do_inta_cycle("after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 200; it++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    irr = 8'($urandom);
                    imr = 8'($urandom & $urandom);
                    tick();
                    n_cmp++;
                    if (int_o !== (model_winner(irr, imr, m_isr, m_low) >= 0)) begin
                        n_bad++; $display("FAIL rand_int it=%0d got %b want %b", it, int_o, !int_o);
                    end
                end
                1: begin
                    aeoi = 1'($urandom_range(0, 1));
`ifdef KF8259_AUTO_ROTATE_EN
                    auto_rot = 1'($urandom_range(0, 1));
`endif
                    base = 5'($urandom);
                    do_inta_cycle("rand_ack");
                end
                2: begin
                    do_eoi("rand_eoi", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           3'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                end
                default: begin
                    irr = irr | 8'($urandom);
                    tick();
                    do_inta_cycle("rand_req_ack");
                end
            endcase
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic_ack();
        test_spurious();
        test_rotate();
        test_auto_eoi();
        test_collisions();
        test_reset_midsequence();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
